// File: rtl/mp_lut_db.sv
// mp_lut_db: memory-polynomial LUT datapath with double-buffered coefficient banks.
// Each of the M+1 taps maps |x[n-k]|^2 to a complex coefficient and multiplies it
// with the delayed sample. Writes land in the shadow bank; a three-state swap FSM
// flips the active bank. Build option: define MP_LUT_SAT_EN to saturate outputs
// (and drive sat_flag_o); otherwise results wrap and sat_flag_o is 0.
// Pipeline (6 cycles): S1 delay line, S2 magnitude, S3 address + bank tag,
// S4 LUT read, S5 complex multiply, S6 round/reduce into the output registers.
// Handshake: in_valid_i qualifies a sample in the cycle it is high; out_valid_o
// rises exactly 6 cycles later; there is no backpressure.
module mp_lut_db #(
  parameter int M          = 3,
  parameter int RESOLUTION = 4096,
  parameter int DW         = 16,
  parameter int FRAC       = 14,
  localparam int AW        = $clog2(RESOLUTION),
  localparam int NW        = (M > 0) ? $clog2(M + 1) : 1
) (
  input  logic                  JESD_clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  input  logic [DW-1:0]         dac_input_i,
  input  logic [DW-1:0]         dac_input_q,
  input  logic [31:0]           coeff_data_i,
  input  logic [AW-1:0]         coeff_addr_i,
  input  logic [NW-1:0]         coeff_num_i,
  input  logic                  coeff_en_i,
  input  logic                  swap_req_i,
  output logic                  swap_ack_o,
  output logic                  active_bank_o,
  output logic                  out_valid_o,
  output logic [DW*(M+1)-1:0]   dpd_data_i,
  output logic [DW*(M+1)-1:0]   dpd_data_q,
  output logic                  sat_flag_o
);

  localparam int PW = DW + 17;
  localparam logic [2*DW-1:0]      MAG_ONE = (2*DW)'(1) << (2*FRAC);
  localparam logic signed [PW-1:0] RND     = PW'(1) << 13;
  localparam logic signed [PW-1:0] MAXV    = PW'((1 << (DW-1)) - 1);
  localparam logic signed [PW-1:0] MINV    = -MAXV - PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SWAP, S_ACK} swap_state_e;

  swap_state_e          state_q;
  logic                 bank_q;
  logic                 ack_q;
  logic [4:0]           vld_q;
  logic                 out_valid_q;
  logic                 bank3_q;
  logic signed [DW-1:0] dly_i_q [0:M];
  logic signed [DW-1:0] dly_q_q [0:M];
  logic [M:0]           sat_tap;

  // Bank swap FSM: request accepted only in IDLE, toggle leaving SWAP, ack during ACK
  always_ff @(posedge JESD_clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      bank_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          if (swap_req_i) state_q <= S_SWAP;
        end
        S_SWAP: begin
          bank_q  <= ~bank_q;
          ack_q   <= 1'b1;
          state_q <= S_ACK;
        end
        S_ACK: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Delay line advances only on valid samples, so tap k always sees x[n-k]
  always_ff @(posedge JESD_clk_i) begin
    if (reset_i) begin
      for (int k = 0; k <= M; k++) begin
        dly_i_q[k] <= '0;
        dly_q_q[k] <= '0;
      end
    end else if (in_valid_i) begin
      dly_i_q[0] <= dac_input_i;
      dly_q_q[0] <= dac_input_q;
      for (int k = 1; k <= M; k++) begin
        dly_i_q[k] <= dly_i_q[k-1];
        dly_q_q[k] <= dly_q_q[k-1];
      end
    end
  end

  // Valid shift register; one bank tag per sample taken in the address stage
  always_ff @(posedge JESD_clk_i) begin
    if (reset_i) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      bank3_q     <= 1'b0;
    end else begin
      vld_q       <= {vld_q[3:0], in_valid_i};
      out_valid_q <= vld_q[4];
      bank3_q     <= bank_q;
    end
  end

  for (genvar k = 0; k <= M; k++) begin : g_tap
    logic [2*DW-1:0]      mag_q;
    logic signed [DW-1:0] s2_i_q, s2_q_q, s3_i_q, s3_q_q, s4_i_q, s4_q_q;
    logic [AW-1:0]        addr_q;
    logic [31:0]          coef_q;
    logic [31:0]          mem_q [0:(2<<AW)-1];
    logic signed [2*DW-1:0] xi_w, xq_w;
    logic signed [PW-1:0] xi5, xq5, ci5, cq5;
    logic signed [PW-1:0] pi_q, pq_q, ri, rq;
    logic [DW-1:0]        oi, oq, dout_i_q, dout_q_q;
    logic                 sat_k;

    assign xi_w = (2*DW)'(dly_i_q[k]);
    assign xq_w = (2*DW)'(dly_q_q[k]);
    assign xi5  = PW'(s4_i_q);
    assign xq5  = PW'(s4_q_q);
    assign ci5  = PW'($signed(coef_q[31:16]));
    assign cq5  = PW'($signed(coef_q[15:0]));
    assign ri   = (pi_q + RND) >>> 14;
    assign rq   = (pq_q + RND) >>> 14;

    // S2..S5 datapath: magnitude, clamped address, LUT read, complex product
    always_ff @(posedge JESD_clk_i) begin
      if (reset_i) begin
        mag_q  <= '0;
        s2_i_q <= '0;  s2_q_q <= '0;
        s3_i_q <= '0;  s3_q_q <= '0;
        s4_i_q <= '0;  s4_q_q <= '0;
        addr_q <= '0;
        coef_q <= '0;
        pi_q   <= '0;  pq_q   <= '0;
      end else begin
        mag_q  <= $unsigned(xi_w * xi_w + xq_w * xq_w);
        s2_i_q <= dly_i_q[k];  s2_q_q <= dly_q_q[k];
        addr_q <= (mag_q >= MAG_ONE) ? {AW{1'b1}} : mag_q[2*FRAC-1 -: AW];
        s3_i_q <= s2_i_q;      s3_q_q <= s2_q_q;
        coef_q <= mem_q[{bank3_q, addr_q}];
        s4_i_q <= s3_i_q;      s4_q_q <= s3_q_q;
        pi_q   <= xi5 * ci5 - xq5 * cq5;
        pq_q   <= xi5 * cq5 + xq5 * ci5;
      end
    end

    // Coefficient writes always target the bank the datapath is not reading
    always_ff @(posedge JESD_clk_i) begin
      if (coeff_en_i && coeff_num_i == NW'(k)) begin
        mem_q[{~bank_q, coeff_addr_i}] <= coeff_data_i;
      end
    end

    // Reduce the rounded result to DW bits (saturate or wrap)
    always_comb begin
      oi    = ri[DW-1:0];
      oq    = rq[DW-1:0];
      sat_k = 1'b0;
`ifdef MP_LUT_SAT_EN
      if (ri > MAXV) begin
        oi = {1'b0, {(DW-1){1'b1}}}; sat_k = 1'b1;
      end else if (ri < MINV) begin
        oi = {1'b1, {(DW-1){1'b0}}}; sat_k = 1'b1;
      end
      if (rq > MAXV) begin
        oq = {1'b0, {(DW-1){1'b1}}}; sat_k = 1'b1;
      end else if (rq < MINV) begin
        oq = {1'b1, {(DW-1){1'b0}}}; sat_k = 1'b1;
      end
`endif
    end

    // Output registers update only with a valid result, otherwise hold
    always_ff @(posedge JESD_clk_i) begin
      if (reset_i) begin
        dout_i_q <= '0;
        dout_q_q <= '0;
      end else if (vld_q[4]) begin
        dout_i_q <= oi;
        dout_q_q <= oq;
      end
    end

    assign dpd_data_i[k*DW +: DW] = dout_i_q;
    assign dpd_data_q[k*DW +: DW] = dout_q_q;
    assign sat_tap[k]             = sat_k;
  end

`ifdef MP_LUT_SAT_EN
  logic sat_q;

  // Saturation flag, aligned with the output it describes
  always_ff @(posedge JESD_clk_i) begin
    if (reset_i) sat_q <= 1'b0;
    else         sat_q <= vld_q[4] & (|sat_tap);
  end

  assign sat_flag_o = sat_q;
`else
  logic unused_sat;
  assign unused_sat = ^{sat_tap, MAXV, MINV};
  assign sat_flag_o = 1'b0;
`endif

  assign swap_ack_o    = ack_q;
  assign active_bank_o = bank_q;
  assign out_valid_o   = out_valid_q;

endmodule

// File: tb/tb_mp_lut_db.sv
// Testbench for mp_lut_db: randomized samples and coefficient writes checked
// against an arithmetic reference model (LUT arrays, sample history, bank timing).
module tb_mp_lut_db;
  localparam int M   = 3;
  localparam int RES = 4096;
  localparam int DW  = 16;
  localparam int FRAC = 14;
  localparam int AW  = 12;
`ifdef MP_LUT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct packed {
    int          cyc;
    logic [63:0] di;
    logic [63:0] dq;
    logic        sat;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid, coeff_en, swap_req;
  logic [15:0]   dac_i, dac_q;
  logic [31:0]   coeff_data;
  logic [AW-1:0] coeff_addr;
  logic [1:0]    coeff_num;
  logic          swap_ack, active_bank, out_valid, sat_flag;
  logic [63:0]   dpd_i, dpd_q;

  mp_lut_db #(.M(M), .RESOLUTION(RES), .DW(DW), .FRAC(FRAC)) dut (
    .JESD_clk_i   (clk),
    .reset_i      (rst),
    .in_valid_i   (in_valid),
    .dac_input_i  (dac_i),
    .dac_input_q  (dac_q),
    .coeff_data_i (coeff_data),
    .coeff_addr_i (coeff_addr),
    .coeff_num_i  (coeff_num),
    .coeff_en_i   (coeff_en),
    .swap_req_i   (swap_req),
    .swap_ack_o   (swap_ack),
    .active_bank_o(active_bank),
    .out_valid_o  (out_valid),
    .dpd_data_i   (dpd_i),
    .dpd_data_q   (dpd_q),
    .sat_flag_o   (sat_flag)
  );

  // ---------------- reference model state ----------------
  logic [31:0] lut_m [0:M][0:1][0:RES-1];
  int          hist_i [0:M];
  int          hist_q [0:M];
  bit          model_bank;
  int          chg_cyc;
  int          ack_due;
  logic [63:0] last_i, last_q;
  exp_t        exp_q[$];
  bit          mon_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int addr_of(input int xi, input int xq);
    longint mag;
    mag = longint'(xi) * xi + longint'(xq) * xq;
    if (mag >= (longint'(1) << (2*FRAC))) return RES - 1;
    return int'((mag >> (2*FRAC - AW)) % RES);
  endfunction

  // {saturated, 16-bit value}
  function automatic logic [16:0] reduce(input longint r);
    logic [63:0] rv;
    if (SAT_EN) begin
      if (r > 32767)  return {1'b1, 16'h7fff};
      if (r < -32768) return {1'b1, 16'h8000};
    end
    rv = r;
    return {1'b0, rv[15:0]};
  endfunction

  task automatic ref_tap(input int xi, input int xq, input logic [31:0] c,
                         output logic [15:0] oi, output logic [15:0] oq, output bit s);
    longint ci, cq, yi, yq;
    logic [16:0] a, b;
    ci = longint'($signed(c[31:16]));
    cq = longint'($signed(c[15:0]));
    yi = longint'(xi) * ci - longint'(xq) * cq;
    yq = longint'(xi) * cq + longint'(xq) * ci;
    a  = reduce((yi + 8192) >>> 14);
    b  = reduce((yq + 8192) >>> 14);
    oi = a[15:0];
    oq = b[15:0];
    s  = a[16] | b[16];
  endtask

  function automatic int rnd_x();
    int r;
    if ($urandom_range(0, 1) == 1) begin
      r = $urandom_range(0, 65535);
      return r - 32768;
    end
    r = $urandom_range(0, 32767);
    return r - 16384;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle_drv(input bit v, input int xi, input int xq,
                           input bit wr, input int wk, input int wa,
                           input logic [31:0] wd, input bit sw);
    bit cur, s;
    exp_t e;
    logic [15:0] oi, oq;
    logic [31:0] xv, qv, av, kv;
    cur = (cyc >= chg_cyc) ? model_bank : !model_bank;
    xv = xi; qv = xq; av = wa; kv = wk;
    in_valid   = v;
    dac_i      = xv[15:0];
    dac_q      = qv[15:0];
    coeff_en   = wr;
    coeff_num  = kv[1:0];
    coeff_addr = av[AW-1:0];
    coeff_data = wd;
    swap_req   = sw;
    if (wr) lut_m[wk][!cur][wa] = wd;
    if (sw) begin
      model_bank = !model_bank;
      chg_cyc    = cyc + 2;
      ack_due    = cyc + 2;
    end
    if (v) begin
      for (int k = M; k > 0; k--) begin
        hist_i[k] = hist_i[k-1];
        hist_q[k] = hist_q[k-1];
      end
      hist_i[0] = xi;
      hist_q[0] = xq;
      e = '0;
      e.cyc = cyc;
      for (int k = 0; k <= M; k++) begin
        ref_tap(hist_i[k], hist_q[k], lut_m[k][model_bank][addr_of(hist_i[k], hist_q[k])], oi, oq, s);
        e.di[k*16 +: 16] = oi;
        e.dq[k*16 +: 16] = oq;
        e.sat = e.sat | s;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; coeff_en = 1'b0; swap_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_drv(1'b0, 0, 0, 1'b0, 0, 0, 32'h0, 1'b0);
  endtask

  task automatic idle_until(input int c);
    for (int i = 0; i < 200 && cyc < c; i++) idle(1);
  endtask

  task automatic sample(input int xi, input int xq);
    cycle_drv(1'b1, xi, xq, 1'b0, 0, 0, 32'h0, 1'b0);
  endtask

  task automatic swap();
    cycle_drv(1'b0, 0, 0, 1'b0, 0, 0, 32'h0, 1'b1);
    idle(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; coeff_en = 1'b0; swap_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k <= M; k++) begin
      hist_i[k] = 0;
      hist_q[k] = 0;
    end
    model_bank = 1'b0;
    chg_cyc    = 0;
    ack_due    = -1;
    last_i     = '0;
    last_q     = '0;
  endtask

  // ---------------- scoreboard monitor ----------------
  exp_t me;
  bit   ev;
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc + 6 < cyc) begin
        me = exp_q.pop_front();
        chk("lost_output", 64'd1, 64'd0);
      end
      ev = (exp_q.size() > 0) && (exp_q[0].cyc + 6 == cyc);
      chk("out_valid", out_valid, ev);
      if (ev) begin
        me = exp_q.pop_front();
        chk("tap_i", dpd_i, me.di);
        chk("tap_q", dpd_q, me.dq);
        chk("sat_flag", sat_flag, me.sat);
        last_i = me.di;
        last_q = me.dq;
      end else begin
        chk("hold_i", dpd_i, last_i);
        chk("hold_q", dpd_q, last_q);
      end
      chk("swap_ack", swap_ack, cyc == ack_due);
      chk("active_bank", active_bank, (cyc >= chg_cyc) ? model_bank : !model_bank);
    end
  end

  // ---------------- stimulus ----------------
  int t0;
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; coeff_en = 1'b0; swap_req = 1'b0;
    dac_i = '0; dac_q = '0; coeff_data = '0; coeff_addr = '0; coeff_num = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;
    chk("rst_valid", out_valid, 64'd0);
    chk("rst_bank", active_bank, 64'd0);
    chk("rst_ack", swap_ack, 64'd0);
    chk("rst_dpd_i", dpd_i, 64'd0);
    chk("rst_sat", sat_flag, 64'd0);

    // Shadow bank 1: tap0 identity, tap1 j, others random
    for (int k = 0; k <= M; k++)
      for (int a = 0; a < RES; a++)
        cycle_drv(1'b0, 0, 0, 1'b1, k, a,
                  (k == 0) ? 32'h4000_0000 : (k == 1) ? 32'h0000_4000 : $urandom(), 1'b0);
    swap();
    chk("swap_bank1", active_bank, 64'd1);

    // Identity on tap0, rotation by j with one-sample delay on tap1
    t0 = cyc;
    sample(32'h2000, 32'h1000);
    sample(32'h1000, 0);
    sample(0, 0);
    idle_until(t0 + 6);
    chk("ident_i", dpd_i[15:0], 64'h2000);
    chk("ident_q", dpd_q[15:0], 64'h1000);
    chk("ident_bank", active_bank, 64'd1);
    idle_until(t0 + 8);
    chk("rot_i", dpd_i[31:16], 64'h0000);
    chk("rot_q", dpd_q[31:16], 64'h1000);

    // Bank 0: random, tap0 top entry holds a saturating coefficient
    for (int k = 0; k <= M; k++)
      for (int a = 0; a < RES; a++)
        cycle_drv(1'b0, 0, 0, 1'b1, k, a,
                  (k == 0 && a == RES - 1) ? 32'h7FFF_0000 : $urandom(), 1'b0);
    swap();
    t0 = cyc;
    sample(32'h7000, 0);
    idle_until(t0 + 6);
    chk("sat_i", dpd_i[15:0], SAT_EN ? 64'h7fff : 64'hdffe);
    chk("sat_flag_dir", sat_flag, SAT_EN ? 64'd1 : 64'd0);

    // Address clamp: unique coefficient at the last entry of bank 1
    cycle_drv(1'b0, 0, 0, 1'b1, 0, RES - 1, 32'h0001_0000, 1'b0);
    swap();
    t0 = cyc;
    sample(32'h7FFF, 32'h7FFF);
    idle_until(t0 + 6);
    chk("clamp_i", dpd_i[15:0], 64'd2);
    chk("clamp_q", dpd_q[15:0], 64'd2);
    idle(4);

    // Random stream with concurrent shadow writes
    for (int i = 0; i < 300; i++)
      cycle_drv($urandom_range(0, 3) != 0, rnd_x(), rnd_x(),
                $urandom_range(0, 1) == 1, $urandom_range(0, M),
                $urandom_range(0, RES - 1), $urandom(), 1'b0);
    idle(8);

    // Continuous stream with a swap in the middle
    for (int i = 0; i < 30; i++)
      cycle_drv(1'b1, rnd_x(), rnd_x(), 1'b0, 0, 0, 32'h0, i == 10);
    idle(8);

    // Reset in the middle of a stream, then reuse retained LUT contents
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        do_reset();
        chk("mid_rst_valid", out_valid, 64'd0);
        chk("mid_rst_dpd_q", dpd_q, 64'd0);
        chk("mid_rst_bank", active_bank, 64'd0);
      end else begin
        sample(rnd_x(), rnd_x());
      end
    end
    idle(8);
    for (int i = 0; i < 12; i++) sample(rnd_x(), rnd_x());
    idle(8);
    swap();
    for (int i = 0; i < 12; i++) sample(rnd_x(), rnd_x());
    idle(10);

    chk("drain_empty", exp_q.size(), 64'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
